matrix_scan_ctrl: RTL and testbench

MATRIX_SCAN_CTRL -- requirements
Module: matrix_scan_ctrl

---
 rtl/matrix_scan_ctrl_pkg.sv | 30 +++
 rtl/matrix_scan_ctrl_if.sv | 17 +
 rtl/matrix_scan_ctrl_scan_image_sel.sv | 40 ++++
 rtl/matrix_scan_ctrl.sv | 67 ++++++
 tb/tb_matrix_scan_ctrl.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/matrix_scan_ctrl_pkg.sv
// matrix_scan_ctrl_pkg: state/phase encodings, image vector and row-drive helpers shared by the scan controller.
package matrix_scan_ctrl_pkg;
    localparam int NUM_ROWS = 7;
    localparam logic [6:0] ROW_OFF = 7'h7F;
    typedef enum logic [1:0] {ST_START, ST_SCAN, ST_BLANK} state_t;
    typedef enum logic {PH_LEVEL, PH_MODE} phase_t;
    typedef struct packed {
        logic critico;
        logic baixo;
        logic medio;
        logic alto;
        logic aspersao;
        logic gotejamento;
    } image_t;
    function automatic logic [6:0] row_drive(logic [2:0] s);
        return ~(7'd1 << s);
    endfunction
    // Level images use alarm priority; mode images prefer sprinkler over drip.
    function automatic image_t select_image(phase_t ph, image_t f);
        image_t r = '0;
        if (ph == PH_LEVEL) begin
            if (f.critico) r.critico = 1'b1;
            else if (f.baixo) r.baixo = 1'b1;
            else if (f.medio) r.medio = 1'b1;
            else if (f.alto) r.alto = 1'b1;
        end else if (f.aspersao) r.aspersao = 1'b1;
        else if (f.gotejamento) r.gotejamento = 1'b1;
        return r;
    endfunction
endpackage

// File: rtl/matrix_scan_ctrl_if.sv
// matrix_scan_ctrl_if: enable/flag inputs and row/image outputs of the matrix scan controller.
interface matrix_scan_ctrl_if;
    logic       disp_en;
    logic       Critico_in, Baixo_in, Medio_in, Alto_in, Aspersao_in, Gotejamento_in;
    logic [2:0] S;
    logic [6:0] Row;
    logic       Critico, Baixo, Medio, Alto, Aspersao, Gotejamento;
    logic       frame_tick;
    modport master (
        input  disp_en, Critico_in, Baixo_in, Medio_in, Alto_in, Aspersao_in, Gotejamento_in,
        output S, Row, Critico, Baixo, Medio, Alto, Aspersao, Gotejamento, frame_tick
    );
    modport slave (
        output disp_en, Critico_in, Baixo_in, Medio_in, Alto_in, Aspersao_in, Gotejamento_in,
        input  S, Row, Critico, Baixo, Medio, Alto, Aspersao, Gotejamento, frame_tick
    );
endinterface

// File: rtl/matrix_scan_ctrl_scan_image_sel.sv
// scan_image_sel: frame counter, level/mode phase alternation and per-frame image register.
module scan_image_sel
    import matrix_scan_ctrl_pkg::*;
#(
    parameter int ALT_FRAMES = 50
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   clr,
    input  logic   load,
    input  logic   wrap,
    input  image_t flags,
    output image_t img
);
    logic [7:0] frame_cnt, frame_nxt;
    phase_t     phase, phase_nxt;
    logic       alt;
    // Mode phase is skipped entirely when no irrigation mode is active.
    always_comb begin
        alt       = wrap && frame_cnt == 8'(ALT_FRAMES - 1);
        frame_nxt = alt ? '0 : frame_cnt + {7'd0, wrap};
        phase_nxt = !alt ? phase :
                    (phase == PH_LEVEL && (flags.aspersao || flags.gotejamento)) ? PH_MODE : PH_LEVEL;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            phase     <= PH_LEVEL;
            img       <= '0;
        end else if (clr) begin
            frame_cnt <= '0;
            phase     <= PH_LEVEL;
            img       <= '0;
        end else if (load) begin
            frame_cnt <= frame_nxt;
            phase     <= phase_nxt;
            img       <= select_image(phase_nxt, flags);
        end
    end
endmodule

// File: rtl/matrix_scan_ctrl.sv
// matrix_scan_ctrl: 7-row LED matrix scanner with tear-free level/mode image alternation.
// Define SCAN_BLANKING_EN to insert one dark cycle after every row.
module matrix_scan_ctrl
    import matrix_scan_ctrl_pkg::*;
#(
    parameter int ROW_DWELL  = 1000,
    parameter int ALT_FRAMES = 50
) (
    input logic clk,
    input logic rst_n,
    matrix_scan_ctrl_if.master bus
);
    state_t      state, state_nxt;
    logic [2:0]  s, s_nxt;
    logic [15:0] dwell, dwell_nxt;
    logic [6:0]  row, row_nxt;
    logic        tick, tick_nxt;
    logic        last, wrap, load;
    image_t      flags, img;
    assign last  = state == ST_SCAN && dwell == 16'(ROW_DWELL - 1);
    assign wrap  = bus.disp_en && last && s == 3'(NUM_ROWS - 1);
    assign load  = bus.disp_en && (state == ST_START || wrap);
    assign flags = {bus.Critico_in, bus.Baixo_in, bus.Medio_in, bus.Alto_in, bus.Aspersao_in, bus.Gotejamento_in};
    assign {bus.Critico, bus.Baixo, bus.Medio, bus.Alto, bus.Aspersao, bus.Gotejamento} = img;
    assign bus.S          = s;
    assign bus.Row        = row;
    assign bus.frame_tick = tick;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_START;
            s     <= '0;
            dwell <= '0;
            row   <= ROW_OFF;
            tick  <= 1'b0;
        end else begin
            state <= state_nxt;
            s     <= s_nxt;
            dwell <= dwell_nxt;
            row   <= row_nxt;
            tick  <= tick_nxt;
        end
    end
    always_comb begin
`ifdef SCAN_BLANKING_EN
        state_nxt = !bus.disp_en ? ST_START : last ? ST_BLANK : ST_SCAN;
`else
        state_nxt = !bus.disp_en ? ST_START : ST_SCAN;
`endif
    end
    // Outputs are computed from next-state values so every port comes straight from a flop.
    always_comb begin
        s_nxt     = (!bus.disp_en || state == ST_START) ? '0 :
                    !last ? s : (s == 3'(NUM_ROWS - 1)) ? '0 : s + 3'd1;
        dwell_nxt = (!bus.disp_en || state != ST_SCAN || last) ? '0 : dwell + 16'd1;
        row_nxt   = state_nxt == ST_SCAN ? row_drive(s_nxt) : ROW_OFF;
        tick_nxt  = state_nxt == ST_SCAN && s_nxt == 3'(NUM_ROWS - 1) && dwell_nxt == 16'(ROW_DWELL - 1);
    end
    scan_image_sel #(.ALT_FRAMES(ALT_FRAMES)) u_image_sel (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!bus.disp_en),
        .load  (load),
        .wrap  (wrap),
        .flags (flags),
        .img   (img)
    );
endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// tb_matrix_scan_ctrl: directed checks of row scanning, image alternation, reset and display-enable behaviour.
module tb_matrix_scan_ctrl;
`ifdef SCAN_BLANKING_EN
    localparam int BL = 1;
`else
    localparam int BL = 0;
`endif
    localparam int DA = 2;
    localparam int DB = 1;
    localparam int PA = DA + BL;
    localparam int FB = 7 * (DB + BL);
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    matrix_scan_ctrl_if ia();
    matrix_scan_ctrl_if ib();
    matrix_scan_ctrl #(.ROW_DWELL(DA), .ALT_FRAMES(50)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    matrix_scan_ctrl #(.ROW_DWELL(DB), .ALT_FRAMES(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));
    always #5 clk = ~clk;
    logic [5:0] img_a, img_b;
    assign img_a = {ia.Critico, ia.Baixo, ia.Medio, ia.Alto, ia.Aspersao, ia.Gotejamento};
    assign img_b = {ib.Critico, ib.Baixo, ib.Medio, ib.Alto, ib.Aspersao, ib.Gotejamento};

    function automatic logic [2:0] exp_s(int k, int d);
        int p = d + BL;
        int r = (k / p) % 7;
        return 3'((k % p == d) ? (r + 1) % 7 : r);
    endfunction
    function automatic logic [6:0] exp_row(int k, int d);
        int p = d + BL;
        logic [6:0] one = 7'd1;
        return (k % p == d) ? 7'h7F : ~(one << ((k / p) % 7));
    endfunction
    function automatic logic exp_tick(int k, int d);
        int p = d + BL;
        return ((k / p) % 7 == 6) && (k % p == d - 1);
    endfunction
    function automatic int exp_frame(int k, int d);
        return (k + BL) / (7 * (d + BL));
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        ia.disp_en = 1'b1;
        {ia.Critico_in, ia.Baixo_in, ia.Medio_in, ia.Alto_in, ia.Aspersao_in, ia.Gotejamento_in} = 6'b111111;
        ib.disp_en = 1'b0;
        {ib.Critico_in, ib.Baixo_in, ib.Medio_in, ib.Alto_in, ib.Aspersao_in, ib.Gotejamento_in} = 6'b000000;
        repeat (3) @(negedge clk);
        checks++; if (ia.Row !== 7'h7F) begin failures++; $display("FAIL reset_row_a got %h exp 7f", ia.Row); end
        checks++; if (ia.S !== 3'd0) begin failures++; $display("FAIL reset_s_a got %0d exp 0", ia.S); end
        checks++; if (img_a !== 6'b0) begin failures++; $display("FAIL reset_img_a got %b exp 000000", img_a); end
        checks++; if (ia.frame_tick !== 1'b0) begin failures++; $display("FAIL reset_tick_a got %b exp 0", ia.frame_tick); end
        checks++; if (ib.Row !== 7'h7F) begin failures++; $display("FAIL reset_row_b got %h exp 7f", ib.Row); end
        checks++; if (ib.S !== 3'd0) begin failures++; $display("FAIL reset_s_b got %0d exp 0", ib.S); end
        checks++; if (img_b !== 6'b0) begin failures++; $display("FAIL reset_img_b got %b exp 000000", img_b); end
    endtask

    task automatic test_scan();
        int n = 2 * 7 * PA + 1;
        rst_n = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            checks++; if (ia.S !== exp_s(k, DA)) begin failures++; $display("FAIL scan_s k=%0d got %0d exp %0d", k, ia.S, exp_s(k, DA)); end
            checks++; if (ia.Row !== exp_row(k, DA)) begin failures++; $display("FAIL scan_row k=%0d got %h exp %h", k, ia.Row, exp_row(k, DA)); end
            checks++; if (ia.frame_tick !== exp_tick(k, DA)) begin failures++; $display("FAIL scan_tick k=%0d got %b exp %b", k, ia.frame_tick, exp_tick(k, DA)); end
            checks++; if (img_a !== 6'b100000) begin failures++; $display("FAIL scan_img k=%0d got %b exp 100000", k, img_a); end
        end
    endtask

    task automatic test_alternate();
        logic [5:0] e;
        {ib.Critico_in, ib.Baixo_in, ib.Medio_in, ib.Alto_in, ib.Aspersao_in, ib.Gotejamento_in} = 6'b010001;
        ib.disp_en = 1'b1;
        for (int k = 0; k < 3 * FB; k++) begin
            @(negedge clk);
            e = (exp_frame(k, DB) % 2 == 0) ? 6'b010000 : 6'b000001;
            checks++; if (ib.S !== exp_s(k, DB)) begin failures++; $display("FAIL alt_s k=%0d got %0d exp %0d", k, ib.S, exp_s(k, DB)); end
            checks++; if (ib.Row !== exp_row(k, DB)) begin failures++; $display("FAIL alt_row k=%0d got %h exp %h", k, ib.Row, exp_row(k, DB)); end
            checks++; if (ib.frame_tick !== exp_tick(k, DB)) begin failures++; $display("FAIL alt_tick k=%0d got %b exp %b", k, ib.frame_tick, exp_tick(k, DB)); end
            checks++; if (img_b !== e) begin failures++; $display("FAIL alt_img k=%0d got %b exp %b", k, img_b, e); end
        end
    endtask

    task automatic test_hold();
        ib.disp_en = 1'b0;
        {ib.Critico_in, ib.Baixo_in, ib.Medio_in, ib.Alto_in, ib.Aspersao_in, ib.Gotejamento_in} = 6'b001000;
        @(negedge clk);
        checks++; if (ib.Row !== 7'h7F) begin failures++; $display("FAIL hold_off_row got %h exp 7f", ib.Row); end
        checks++; if (ib.S !== 3'd0) begin failures++; $display("FAIL hold_off_s got %0d exp 0", ib.S); end
        checks++; if (img_b !== 6'b0) begin failures++; $display("FAIL hold_off_img got %b exp 000000", img_b); end
        ib.disp_en = 1'b1;
        for (int k = 0; k < 3 * FB; k++) begin
            @(negedge clk);
            checks++; if (ib.S !== exp_s(k, DB)) begin failures++; $display("FAIL hold_s k=%0d got %0d exp %0d", k, ib.S, exp_s(k, DB)); end
            checks++; if (img_b !== 6'b001000) begin failures++; $display("FAIL hold_img k=%0d got %b exp 001000", k, img_b); end
            if (k == 2) begin ib.Aspersao_in = 1'b1; ib.Critico_in = 1'b1; end
            if (k == 4) begin ib.Aspersao_in = 1'b0; ib.Critico_in = 1'b0; end
        end
    endtask

    task automatic test_reset_mid();
        ia.disp_en = 1'b0;
        @(negedge clk);
        ia.disp_en = 1'b1;
        for (int k = 0; k <= 3 * PA; k++) @(negedge clk);
        checks++; if (ia.S !== 3'd3) begin failures++; $display("FAIL mid_pre_s got %0d exp 3", ia.S); end
        checks++; if (ia.Row !== 7'h77) begin failures++; $display("FAIL mid_pre_row got %h exp 77", ia.Row); end
        #2 rst_n = 1'b0;
        ia.Critico_in = 1'b0;
        #1;
        checks++; if (ia.Row !== 7'h7F) begin failures++; $display("FAIL mid_async_row got %h exp 7f", ia.Row); end
        checks++; if (ia.S !== 3'd0) begin failures++; $display("FAIL mid_async_s got %0d exp 0", ia.S); end
        checks++; if (img_a !== 6'b0) begin failures++; $display("FAIL mid_async_img got %b exp 000000", img_a); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k <= 7 * PA; k++) begin
            @(negedge clk);
            checks++; if (ia.S !== exp_s(k, DA)) begin failures++; $display("FAIL mid_s k=%0d got %0d exp %0d", k, ia.S, exp_s(k, DA)); end
            checks++; if (ia.Row !== exp_row(k, DA)) begin failures++; $display("FAIL mid_row k=%0d got %h exp %h", k, ia.Row, exp_row(k, DA)); end
            checks++; if (img_a !== 6'b010000) begin failures++; $display("FAIL mid_img k=%0d got %b exp 010000", k, img_a); end
        end
    endtask

    task automatic test_disp_drop();
        for (int i = 0; i < 100 && !(ia.S === 3'd5 && ia.Row === 7'h5F); i++) @(negedge clk);
        checks++; if (ia.Row !== 7'h5F) begin failures++; $display("FAIL drop_wait_row5 got %h exp 5f", ia.Row); end
        ia.disp_en = 1'b0;
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            checks++; if (ia.Row !== 7'h7F) begin failures++; $display("FAIL drop_row j=%0d got %h exp 7f", j, ia.Row); end
            checks++; if (ia.S !== 3'd0) begin failures++; $display("FAIL drop_s j=%0d got %0d exp 0", j, ia.S); end
            checks++; if (img_a !== 6'b0) begin failures++; $display("FAIL drop_img j=%0d got %b exp 000000", j, img_a); end
            checks++; if (ia.frame_tick !== 1'b0) begin failures++; $display("FAIL drop_tick j=%0d got %b exp 0", j, ia.frame_tick); end
        end
        ia.disp_en = 1'b1;
        for (int k = 0; k <= 7 * PA; k++) begin
            @(negedge clk);
            checks++; if (ia.S !== exp_s(k, DA)) begin failures++; $display("FAIL drop_s k=%0d got %0d exp %0d", k, ia.S, exp_s(k, DA)); end
            checks++; if (ia.Row !== exp_row(k, DA)) begin failures++; $display("FAIL drop_row k=%0d got %h exp %h", k, ia.Row, exp_row(k, DA)); end
            checks++; if (ia.frame_tick !== exp_tick(k, DA)) begin failures++; $display("FAIL drop_tick k=%0d got %b exp %b", k, ia.frame_tick, exp_tick(k, DA)); end
            checks++; if (img_a !== 6'b010000) begin failures++; $display("FAIL drop_img k=%0d got %b exp 010000", k, img_a); end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_alternate();
        test_hold();
        test_reset_mid();
        test_disp_drop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
